// File: rtl/ip4_rtl_pkg.sv
// Shared types and constants for the ip4 read-address arbiter.
package ip4_rtl_pkg;

   localparam int AR_AW_MAX = 64;
   localparam int AR_ID_MAX = 16;
   localparam int CNT_W     = 4;

   // Outstanding-burst counter; 4 bits covers MAX_OUTS up to 15.
   typedef logic [CNT_W-1:0] outs_cnt_t;

   // Width of the channel-index field prepended to the downstream ID.
   function automatic int ch_width(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   localparam int CW_DEF = ch_width(4);

   // Registered AR payload, sized for the widest supported configuration.
   typedef struct packed {
      logic [AR_AW_MAX-1:0] addr;
      logic [7:0]           len;
      logic [AR_ID_MAX-1:0] id;
      logic [3:0]           qos;
   } ar_req_t;

endpackage

// File: rtl/ip4_rtl_rr_arb.sv
// Round-robin arbiter: search starts one above the last granted channel.
module ip4_rtl_rr_arb
   import ip4_rtl_pkg::*;
#(
   parameter  int NCH = 4,
   localparam int CW  = ch_width(NCH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] req,
   input  logic           en,
   output logic [NCH-1:0] gnt
);

   logic [CW-1:0] ptr_q;
   logic          found;
   int            gidx;
   int            idx;

   // First requester found above the pointer wins (one-hot).
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      gidx  = 0;
      idx   = 0;
      for (int off = 1; off <= NCH; off++) begin
         idx = (int'(ptr_q) + off) % NCH;
         if (en && !found && req[idx]) begin
            found     = 1'b1;
            gnt[idx]  = 1'b1;
            gidx      = idx;
         end
      end
   end

   // Pointer remembers the last winner; reset value makes channel 0 first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr_q <= CW'(NCH - 1);
      else if (found)
         ptr_q <= CW'(gidx);
   end

endmodule

// File: rtl/ip4_rtl_axi_rdarb.sv
// AXI read-channel arbiter: NCH requesters onto one downstream AR/R port.
// Optional QoS priority selected with `define IP4_RDARB_QOS_EN.
module ip4_rtl_axi_rdarb
   import ip4_rtl_pkg::*;
#(
   parameter  int NCH      = 4,
   parameter  int AW       = 32,
   parameter  int IDW      = 4,
   parameter  int DW       = 64,
   parameter  int MAX_OUTS = 4,
   localparam int CW       = ch_width(NCH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NCH-1:0]      s_arvalid,
   output logic [NCH-1:0]      s_arready,
   input  logic [NCH*AW-1:0]   s_araddr,
   input  logic [NCH*8-1:0]    s_arlen,
   input  logic [NCH*IDW-1:0]  s_arid,
`ifdef IP4_RDARB_QOS_EN
   input  logic [NCH*4-1:0]    s_arqos,
   output logic [3:0]          m_arqos,
`endif
   output logic [NCH-1:0]      s_rvalid,
   input  logic [NCH-1:0]      s_rready,
   output logic [DW-1:0]       s_rdata,
   output logic [IDW-1:0]      s_rid,
   output logic                s_rlast,
   output logic                m_arvalid,
   input  logic                m_arready,
   output logic [AW-1:0]       m_araddr,
   output logic [7:0]          m_arlen,
   output logic [IDW+CW-1:0]   m_arid,
   input  logic                m_rvalid,
   output logic                m_rready,
   input  logic [DW-1:0]       m_rdata,
   input  logic [IDW+CW-1:0]   m_rid,
   input  logic                m_rlast,
   output logic                err_o
);

   localparam int IW = IDW + CW;

   outs_cnt_t      cnt_q [NCH];
   logic           active_q;
   logic [NCH-1:0] elig;
   logic [NCH-1:0] cand;
   logic [NCH-1:0] req_mask;
   logic [NCH-1:0] gnt;
   logic           ar_free;
   logic           arb_en;
   ar_req_t        sel;
   ar_req_t        ar_q;
   logic [CW-1:0]  rch;
   logic           ch_ok;
   logic           r_last_hs;
   logic           unused_ar;

   // A channel may compete only while it has outstanding room.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NCH; i++)
         elig[i] = s_arvalid[i] && (int'(cnt_q[i]) < MAX_OUTS);
   end

`ifdef IP4_RDARB_QOS_EN
   logic [3:0] qmax;

   // Only eligible channels at the highest qos level go to the RR stage.
   always_comb begin
      qmax = '0;
      cand = '0;
      for (int i = 0; i < NCH; i++)
         if (elig[i] && (s_arqos[i*4 +: 4] > qmax))
            qmax = s_arqos[i*4 +: 4];
      for (int i = 0; i < NCH; i++)
         cand[i] = elig[i] && (s_arqos[i*4 +: 4] == qmax);
   end

   assign m_arqos = ar_q.qos;
`else
   assign cand = elig;
`endif

   // active_q keeps grants off during and on the edge of reset release.
   assign ar_free   = !m_arvalid || m_arready;
   assign arb_en    = active_q && ar_free;
   assign req_mask  = arb_en ? cand : '0;
   assign s_arready = gnt;

   ip4_rtl_rr_arb #(.NCH(NCH)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_mask),
      .en    (arb_en),
      .gnt   (gnt)
   );

   // Winner payload mux; channel index is prepended to the upstream ID.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt[i]) begin
            sel.addr = AR_AW_MAX'(s_araddr[i*AW +: AW]);
            sel.len  = s_arlen[i*8 +: 8];
            sel.id   = AR_ID_MAX'({CW'(i), s_arid[i*IDW +: IDW]});
`ifdef IP4_RDARB_QOS_EN
            sel.qos  = s_arqos[i*4 +: 4];
`endif
         end
      end
   end

   // Output AR register: loads on grant, holds until accepted downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q  <= 1'b0;
         m_arvalid <= 1'b0;
         ar_q      <= '0;
      end else begin
         active_q <= 1'b1;
         if (|gnt) begin
            m_arvalid <= 1'b1;
            ar_q      <= sel;
         end else if (m_arready) begin
            m_arvalid <= 1'b0;
         end
      end
   end

   assign m_araddr  = ar_q.addr[AW-1:0];
   assign m_arlen   = ar_q.len;
   assign m_arid    = ar_q.id[IW-1:0];
   assign unused_ar = ^ar_q;

   // R routing by the channel field; unknown channels are accepted and dropped.
   assign rch   = m_rid[IW-1:IDW];
   assign ch_ok = int'(rch) < NCH;

   always_comb begin
      s_rvalid = '0;
      m_rready = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if (rch == CW'(i)) begin
            s_rvalid[i] = m_rvalid;
            m_rready    = s_rready[i];
         end
      end
   end

   assign s_rdata   = m_rdata;
   assign s_rid     = m_rid[IDW-1:0];
   assign s_rlast   = m_rlast;
   assign r_last_hs = m_rvalid && m_rready && m_rlast;

   // Outstanding counters saturate at zero; bad routing or underflow is sticky.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++)
            cnt_q[i] <= '0;
         err_o <= 1'b0;
      end else begin
         if (m_rvalid && !ch_ok)
            err_o <= 1'b1;
         for (int i = 0; i < NCH; i++) begin
            if (gnt[i] && !(r_last_hs && rch == CW'(i)))
               cnt_q[i] <= cnt_q[i] + 1'b1;
            else if (!gnt[i] && r_last_hs && rch == CW'(i) && cnt_q[i] != '0)
               cnt_q[i] <= cnt_q[i] - 1'b1;
            if (r_last_hs && rch == CW'(i) && cnt_q[i] == '0)
               err_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ip4_rtl_axi_rdarb.sv
// Directed bench for ip4_rtl_axi_rdarb with an AR scoreboard.
module tb_ip4_rtl_axi_rdarb;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    s_arvalid;
   logic [3:0]    s_arready;
   logic [127:0]  s_araddr;
   logic [31:0]   s_arlen;
   logic [15:0]   s_arid;
`ifdef IP4_RDARB_QOS_EN
   logic [15:0]   s_arqos;
   logic [3:0]    m_arqos;
`endif
   logic [3:0]    s_rvalid;
   logic [3:0]    s_rready;
   logic [63:0]   s_rdata;
   logic [3:0]    s_rid;
   logic          s_rlast;
   logic          m_arvalid;
   logic          m_arready;
   logic [31:0]   m_araddr;
   logic [7:0]    m_arlen;
   logic [5:0]    m_arid;
   logic          m_rvalid;
   logic          m_rready;
   logic [63:0]   m_rdata;
   logic [5:0]    m_rid;
   logic          m_rlast;
   logic          err_o;

   int            n_pass  = 0;
   int            n_total = 0;
   logic [63:0]   sb [$];
   logic [63:0]   sb_exp;

   always #5 clk = ~clk;

   ip4_rtl_axi_rdarb dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .s_araddr  (s_araddr),
      .s_arlen   (s_arlen),
      .s_arid    (s_arid),
`ifdef IP4_RDARB_QOS_EN
      .s_arqos   (s_arqos),
      .m_arqos   (m_arqos),
`endif
      .s_rvalid  (s_rvalid),
      .s_rready  (s_rready),
      .s_rdata   (s_rdata),
      .s_rid     (s_rid),
      .s_rlast   (s_rlast),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_araddr  (m_araddr),
      .m_arlen   (m_arlen),
      .m_arid    (m_arid),
      .m_rvalid  (m_rvalid),
      .m_rready  (m_rready),
      .m_rdata   (m_rdata),
      .m_rid     (m_rid),
      .m_rlast   (m_rlast),
      .err_o     (err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] exp_ar(input int ch);
      return {18'b0, 2'(ch), s_arid[ch*4 +: 4], s_araddr[ch*32 +: 32], s_arlen[ch*8 +: 8]};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One rlast beat for channel ch, upstream ready on that channel only.
   task automatic rbeat(input int ch, input logic [3:0] id);
      m_rvalid = 1'b1;
      m_rid    = {2'(ch), id};
      m_rlast  = 1'b1;
      m_rdata  = 64'hA5A5_0000_0000_0000 | 64'(ch);
      s_rready = 4'(1 << ch);
      @(negedge clk);
      chk("r_route", 64'(s_rvalid), 64'(1 << ch));
      chk("r_id", 64'(s_rid), 64'(id));
      chk("r_ready", 64'(m_rready), 64'd1);
      @(posedge clk);
      #1;
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      s_rready = '0;
   endtask

   // Scoreboard: every accepted downstream AR must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && m_arvalid && m_arready) begin
         if (sb.size() == 0) begin
            n_total++;
            $error("FAIL sb_unexpected_ar: got arid %0h addr %0h want no transfer", m_arid, m_araddr);
         end else begin
            sb_exp = sb.pop_front();
            chk("ar_xfer", {18'b0, m_arid, m_araddr, m_arlen}, sb_exp);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      s_arvalid = 4'hF;
      m_arready = 1'b1;
      m_rvalid  = 1'b0;
      m_rid     = '0;
      m_rlast   = 1'b0;
      m_rdata   = '0;
      s_rready  = '0;
`ifdef IP4_RDARB_QOS_EN
      s_arqos   = '0;
`endif
      for (int i = 0; i < 4; i++) begin
         s_araddr[i*32 +: 32] = 32'(32'h1000 * (i + 1));
         s_arlen[i*8 +: 8]    = 8'(i + 1);
         s_arid[i*4 +: 4]     = 4'(8 + i);
      end

      // reset state with requests pending
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_arvalid", 64'(m_arvalid), 64'd0);
      chk("rst_arready", 64'(s_arready), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_araddr", 64'(m_araddr), 64'd0);
      chk("rst_arid", 64'(m_arid), 64'd0);
      s_arvalid = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // round robin across all four channels, one grant per cycle
      s_arvalid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         sb.push_back(exp_ar(k % 4));
         @(negedge clk);
         chk("rr_grant", 64'(s_arready), 64'(1 << (k % 4)));
         @(posedge clk);
         #1;
      end
      s_arvalid = '0;
      idle(2);
      for (int r = 0; r < 2; r++)
         for (int ch = 0; ch < 4; ch++)
            rbeat(ch, 4'(8 + ch));

      // outstanding limit on channel 2
      s_arvalid = 4'b0100;
      for (int k = 0; k < 8; k++) begin
         if (k < 4) sb.push_back(exp_ar(2));
         @(negedge clk);
         chk("outs_gate", 64'(s_arready), (k < 4) ? 64'h4 : 64'h0);
         @(posedge clk);
         #1;
      end
      m_rvalid = 1'b1;
      m_rid    = {2'd2, 4'hA};
      m_rlast  = 1'b1;
      s_rready = 4'b0100;
      @(negedge clk);
      chk("outs_same_cycle", 64'(s_arready), 64'h0);
      @(posedge clk);
      #1;
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      s_rready = '0;
      sb.push_back(exp_ar(2));
      @(negedge clk);
      chk("outs_regrant", 64'(s_arready), 64'h4);
      @(posedge clk);
      #1;
      s_arvalid = '0;
      idle(1);
      for (int r = 0; r < 4; r++)
         rbeat(2, 4'hA);

      // downstream stall holds the AR register
      m_arready = 1'b0;
      s_arvalid = 4'b0010;
      sb.push_back(exp_ar(1));
      @(negedge clk);
      chk("stall_grant", 64'(s_arready), 64'h2);
      @(posedge clk);
      #1;
      s_araddr[32 +: 32] = 32'hDEAD_0000;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_valid", 64'(m_arvalid), 64'd1);
         chk("stall_addr", 64'(m_araddr), 64'h2000);
         chk("stall_no_grant", 64'(s_arready), 64'h0);
         @(posedge clk);
         #1;
      end
      s_arvalid = '0;
      m_arready = 1'b1;
      @(negedge clk);
      chk("stall_release", 64'(m_arvalid), 64'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stall_single", 64'(m_arvalid), 64'd0);
      @(posedge clk);
      #1;
      s_araddr[32 +: 32] = 32'h2000;
      rbeat(1, 4'h9);

      // R routing for m_rid 6'h25
      m_rvalid = 1'b1;
      m_rid    = 6'h25;
      m_rlast  = 1'b0;
      m_rdata  = 64'h0123_4567_89AB_CDEF;
      s_rready = 4'b0100;
      @(negedge clk);
      chk("route_valid", 64'(s_rvalid), 64'h4);
      chk("route_id", 64'(s_rid), 64'h5);
      chk("route_data", s_rdata, 64'h0123_4567_89AB_CDEF);
      chk("route_ready_hi", 64'(m_rready), 64'd1);
      s_rready = 4'b1011;
      #1;
      chk("route_ready_lo", 64'(m_rready), 64'd0);
      @(posedge clk);
      #1;
      m_rvalid = 1'b0;
      s_rready = '0;

      // simultaneous grant and rlast on channel 1, then underflow
      s_arvalid = 4'b0010;
      for (int k = 0; k < 2; k++) begin
         sb.push_back(exp_ar(1));
         @(negedge clk);
         chk("cnt_fill_grant", 64'(s_arready), 64'h2);
         @(posedge clk);
         #1;
      end
      s_arvalid = '0;
      idle(1);
      @(negedge clk);
      chk("cnt_two", 64'(dut.cnt_q[1]), 64'd2);
      @(posedge clk);
      #1;
      s_arvalid = 4'b0010;
      sb.push_back(exp_ar(1));
      m_rvalid = 1'b1;
      m_rid    = {2'd1, 4'h9};
      m_rlast  = 1'b1;
      s_rready = 4'b0010;
      @(negedge clk);
      chk("cnt_both_grant", 64'(s_arready), 64'h2);
      @(posedge clk);
      #1;
      s_arvalid = '0;
      m_rvalid  = 1'b0;
      m_rlast   = 1'b0;
      s_rready  = '0;
      @(negedge clk);
      chk("cnt_same_cycle", 64'(dut.cnt_q[1]), 64'd2);
      @(posedge clk);
      #1;
      rbeat(1, 4'h9);
      rbeat(1, 4'h9);
      @(negedge clk);
      chk("cnt_drained", 64'(dut.cnt_q[1]), 64'd0);
      chk("err_clean", 64'(err_o), 64'd0);
      @(posedge clk);
      #1;
      rbeat(1, 4'h9);
      @(negedge clk);
      chk("cnt_underflow", 64'(dut.cnt_q[1]), 64'd0);
      chk("err_underflow", 64'(err_o), 64'd1);
      @(posedge clk);
      #1;

`ifdef IP4_RDARB_QOS_EN
      // higher qos wins outright, equal qos falls back to round robin
      s_arqos   = 16'h7001;
      s_arvalid = 4'b1001;
      for (int k = 0; k < 3; k++) begin
         sb.push_back(exp_ar(3));
         @(negedge clk);
         chk("qos_high", 64'(s_arready), 64'h8);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("qos_out", 64'(m_arqos), 64'h7);
      s_arqos = 16'h1001;
      @(posedge clk);
      #1;
      sb.push_back(exp_ar(0));
      @(negedge clk);
      chk("qos_tie_a", 64'(s_arready), 64'h1);
      @(posedge clk);
      #1;
      sb.push_back(exp_ar(3));
      @(negedge clk);
      chk("qos_tie_b", 64'(s_arready), 64'h8);
      @(posedge clk);
      #1;
      s_arvalid = '0;
      idle(2);
      for (int r = 0; r < 4; r++)
         rbeat(3, 4'hB);
      rbeat(0, 4'h8);
`endif

      // reset with a pending AR discards it cleanly
      m_arready = 1'b0;
      s_arvalid = 4'b0001;
      @(negedge clk);
      chk("mid_grant", 64'(s_arready), 64'h1);
      @(posedge clk);
      #1;
      s_arvalid = '0;
      @(negedge clk);
      chk("mid_pending", 64'(m_arvalid), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(m_arvalid), 64'd0);
      chk("mid_rst_err", 64'(err_o), 64'd0);
      chk("mid_rst_addr", 64'(m_araddr), 64'd0);
      idle(2);
      rst_n     = 1'b1;
      m_arready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("mid_release_quiet", 64'(m_arvalid), 64'd0);
         @(posedge clk);
         #1;
      end
      s_arvalid = 4'b0001;
      sb.push_back(exp_ar(0));
      @(negedge clk);
      chk("post_rst_grant", 64'(s_arready), 64'h1);
      @(posedge clk);
      #1;
      s_arvalid = '0;
      idle(3);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ip4_rtl_axi_rdarb.md
IP4_RTL_AXI_RDARB -- requirements
Module: ip4_rtl_axi_rdarb

Interface
REQ-001 Parameter NCH, default 4: number of read requester channels, range 2..8.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter IDW, default 4: per-channel ID width.
REQ-004 Parameter DW, default 64: read data width.
REQ-005 Parameter MAX_OUTS, default 4: maximum outstanding bursts per channel, range 1..15.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset: ports clk, rst_n.
REQ-007 clk  in  1  clock; all state changes on the rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 s_arvalid/s_arready  in/out  NCH  per-channel AR handshake.
REQ-010 s_araddr  in  NCH*AW; s_arlen  in  NCH*8; s_arid  in  NCH*IDW: per-channel AR payload.
REQ-011 s_rvalid/s_rready  out/in  NCH; s_rdata  out  DW; s_rid  out  IDW; s_rlast  out  1: shared R payload, per-channel valid.
REQ-012 m_arvalid/m_arready  out/in  1; m_araddr AW; m_arlen 8; m_arid IDW+CW (CW=clog2(NCH)): downstream AR.
REQ-013 m_rvalid/m_rready  in/out  1; m_rdata DW; m_rid IDW+CW; m_rlast 1: downstream R.

Function
REQ-014 Eligible channel: s_arvalid high and outstanding count < MAX_OUTS.
REQ-015 Round-robin among eligible channels; search starts one above the last granted channel; after reset, channel 0 has highest priority.
REQ-016 Grant only while output AR register is empty, or being drained this cycle (m_arvalid & m_arready).
REQ-017 s_arready[i] high only in the cycle channel i is granted; at most one bit set.
REQ-018 Granted request is registered: m_arvalid rises the next cycle (latency 1); m_arid = {channel index, s_arid}.
REQ-019 m_arvalid and m_ar* hold stable until m_arready; back-to-back grants give one AR per cycle.
REQ-020 Outstanding counter per channel: +1 on grant, -1 on R handshake with m_rlast; both in the same cycle leave it unchanged.
REQ-021 R routing: ch = m_rid[IDW+CW-1:IDW]; s_rvalid[ch]=m_rvalid; m_rready=s_rready[ch]; s_rid=m_rid[IDW-1:0]; combinational, zero latency.
REQ-022 m_rid channel field >= NCH: m_rready forced high, beat dropped, sticky err_o (out, 1) set until reset.
REQ-023 Counter underflow (rlast for a channel at 0) SHALL not wrap; counter holds at 0 and sets err_o.

Reset
REQ-024 Under rst_n low: m_arvalid=0, s_arready=0, all counters=0, RR pointer=NCH-1, err_o=0, m_ar* payload=0.
REQ-025 Reset mid-transaction discards the pending AR and all counts; no output pulse on release.

Configuration
REQ-026 With IP4_RDARB_QOS_EN defined: input s_arqos (NCH*4); only eligible channels with the highest qos compete, ties by RR; m_arqos (out, 4) carries the winner's qos.
REQ-027 Without IP4_RDARB_QOS_EN: s_arqos/m_arqos ports absent; pure RR per REQ-015.

Structure
REQ-028 ip4_rtl_pkg SHALL hold the outstanding-counter typedef, clog2 channel-width constant and the ar_req_t payload struct (addr, len, id, qos).
REQ-029 One sub-module ip4_rtl_rr_arb: NCH-wide request mask in, one-hot grant out, pointer update on enable.

Verification
REQ-030 All 4 channels assert arvalid continuously, m_arready=1 -> grants ch0,1,2,3,0,... one per cycle; m_arid[5:4]=0,1,2,3.
REQ-031 Ch2 issues 4 ARs, no R returned, MAX_OUTS=4 -> 5th request from ch2 never granted; one rlast with m_rid[5:4]=2 -> granted next eligible cycle.
REQ-032 m_arready low 5 cycles -> m_arvalid and m_araddr stable, no s_arready pulses; release -> single transfer.
REQ-033 R beat with m_rid=6'h25 -> s_rvalid=4'b0100, s_rid=4'h5; m_rready follows s_rready[2].
REQ-034 Grant and rlast for ch1 in the same cycle at count 2 -> count stays 2; rlast at count 0 -> count 0, err_o=1.
REQ-035 QoS build: ch0 qos=1, ch3 qos=7 both valid -> ch3 granted repeatedly; equal qos -> RR alternation.
